// File: rtl/pole_predictor_pkg.sv
// rtl/pole_predictor_pkg.sv - shared state encoding, limits and helpers for the pole predictor
package pole_predictor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL1 = 2'd1,
        MUL2 = 2'd2,
        SUM  = 2'd3
    } state_e;

    localparam logic [15:0] A2UL       = 16'd12288;
    localparam logic [15:0] A2LL       = 16'd53248;
    localparam logic [12:0] FMULT_BIAS = 13'd48;

    function automatic logic [3:0] bit_length13(input logic [12:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 13; i++) begin
            if (v[i]) n = 4'(i + 1);
        end
        return n;
    endfunction

    function automatic logic [15:0] limc(input logic [15:0] a2t);
        logic [15:0] r;
        if ($signed(a2t) > $signed(A2UL))      r = A2UL;
        else if ($signed(a2t) < $signed(A2LL)) r = A2LL;
        else                                   r = a2t;
        return r;
    endfunction

endpackage

// File: rtl/pole_predictor_if.sv
// rtl/pole_predictor_if.sv - coefficient, operand and result bundle of the pole predictor
interface pole_predictor_if;
    logic        upd;
    logic [15:0] A2T;
    logic [15:0] A1;
    logic [10:0] SR1;
    logic [10:0] SR2;
    logic        start;
    logic [15:0] A2;
    logic        busy;
    logic        done;
    logic [15:0] WA1;
    logic [15:0] WA2;
    logic [15:0] SEP;

    modport master (
        output upd, A2T, A1, SR1, SR2, start,
        input  A2, busy, done, WA1, WA2, SEP
    );

    modport slave (
        input  upd, A2T, A1, SR1, SR2, start,
        output A2, busy, done, WA1, WA2, SEP
    );
endinterface

// File: rtl/pole_predictor_fmult.sv
// rtl/pole_predictor_fmult.sv - combinational G.726 FMULT: fixed-point coefficient times float signal
module fmult
    import pole_predictor_pkg::*;
(
    input  logic [15:0] an,
    input  logic [10:0] sr,
    output logic [15:0] wan
);

    logic [15:0] an_abs;
    logic [12:0] an_mag;
    logic [3:0]  an_exp;
    logic [18:0] an_norm;
    logic [5:0]  an_mant;
    logic [4:0]  w_exp;
    logic [12:0] w_prod;
    logic [7:0]  w_mant;
    logic [16:0] w_scaled;
    logic [14:0] w_mag;

    always_comb begin
        an_abs  = an[15] ? (~an + 16'd1) : an;
        an_mag  = an_abs[14:2];
        an_exp  = bit_length13(an_mag);
        an_norm = {an_mag, 6'b0} >> an_exp;
        an_mant = (an_mag == 13'd0) ? 6'd32 : an_norm[5:0];
        w_exp   = {1'b0, sr[9:6]} + {1'b0, an_exp};
        // Mantissa product never exceeds 63*63+48, so 13 bits hold it without overflow.
        w_prod  = ({7'b0, sr[5:0]} * {7'b0, an_mant}) + FMULT_BIAS;
        w_mant  = w_prod[11:4];
        if (w_exp <= 5'd26) w_scaled = {2'b0, w_mant, 7'b0} >> (5'd26 - w_exp);
        else                w_scaled = {2'b0, w_mant, 7'b0} << (w_exp - 5'd26);
        w_mag   = w_scaled[14:0];
        wan     = (sr[10] ^ an[15]) ? (16'd0 - {1'b0, w_mag}) : {1'b0, w_mag};
    end

endmodule

// File: rtl/pole_predictor.sv
// rtl/pole_predictor.sv - A2 limiter and three-step pole-section evaluator sharing one fmult
module pole_predictor
    import pole_predictor_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic test_mode,
    input  logic scan_enable,
    input  logic scan_in0,
    input  logic scan_in1,
    input  logic scan_in2,
    input  logic scan_in3,
    input  logic scan_in4,
    output logic scan_out0,
    output logic scan_out1,
    output logic scan_out2,
    output logic scan_out3,
    output logic scan_out4,
    pole_predictor_if.slave bus
);

    state_e      state_q, state_d;
    logic [15:0] a2_q, a2_d;
    logic [15:0] a1_cap_q, a1_cap_d;
    logic [15:0] a2_cap_q, a2_cap_d;
    logic [10:0] sr1_cap_q, sr1_cap_d;
    logic [10:0] sr2_cap_q, sr2_cap_d;
    logic [15:0] wa1_q, wa1_d;
    logic [15:0] wa2_q, wa2_d;
    logic [15:0] sep_q, sep_d;
    logic        done_q, done_d;

    logic [15:0] mul_an;
    logic [10:0] mul_sr;
    logic [15:0] mul_w;

    wire unused_scan = &{1'b0, test_mode, scan_enable,
                         scan_in0, scan_in1, scan_in2, scan_in3, scan_in4};

    // The single multiplier sees the a1 pair in MUL1 and the a2 pair otherwise.
    assign mul_an = (state_q == MUL1) ? a1_cap_q  : a2_cap_q;
    assign mul_sr = (state_q == MUL1) ? sr1_cap_q : sr2_cap_q;

    fmult u_fmult (
        .an  (mul_an),
        .sr  (mul_sr),
        .wan (mul_w)
    );

    always_comb begin
        state_d   = state_q;
        a2_d      = bus.upd ? limc(bus.A2T) : a2_q;
        a1_cap_d  = a1_cap_q;
        a2_cap_d  = a2_cap_q;
        sr1_cap_d = sr1_cap_q;
        sr2_cap_d = sr2_cap_q;
        wa1_d     = wa1_q;
        wa2_d     = wa2_q;
        sep_d     = sep_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a1_cap_d  = bus.A1;
                    a2_cap_d  = a2_q;
                    sr1_cap_d = bus.SR1;
                    sr2_cap_d = bus.SR2;
                    state_d   = MUL1;
                end
            end
            MUL1: begin
                wa1_d   = mul_w;
                state_d = MUL2;
            end
            MUL2: begin
                wa2_d   = mul_w;
                state_d = SUM;
            end
            SUM: begin
                sep_d   = wa1_q + wa2_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            a2_q      <= 16'd0;
            a1_cap_q  <= 16'd0;
            a2_cap_q  <= 16'd0;
            sr1_cap_q <= 11'd0;
            sr2_cap_q <= 11'd0;
            wa1_q     <= 16'd0;
            wa2_q     <= 16'd0;
            sep_q     <= 16'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a2_q      <= a2_d;
            a1_cap_q  <= a1_cap_d;
            a2_cap_q  <= a2_cap_d;
            sr1_cap_q <= sr1_cap_d;
            sr2_cap_q <= sr2_cap_d;
            wa1_q     <= wa1_d;
            wa2_q     <= wa2_d;
            sep_q     <= sep_d;
            done_q    <= done_d;
        end
    end

    assign bus.A2   = a2_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.WA1  = wa1_q;
    assign bus.WA2  = wa2_q;
    assign bus.SEP  = sep_q;

    assign scan_out0 = 1'b0;
    assign scan_out1 = 1'b0;
    assign scan_out2 = 1'b0;
    assign scan_out3 = 1'b0;
    assign scan_out4 = 1'b0;

endmodule

// File: tb/tb_pole_predictor.sv
// tb/tb_pole_predictor.sv - directed and randomized checks of pole_predictor against an arithmetic model
module tb_pole_predictor;

    logic clk = 1'b0;
    logic reset;
    logic test_mode, scan_enable;
    logic scan_in0, scan_in1, scan_in2, scan_in3, scan_in4;
    logic scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] a2_model;

    pole_predictor_if bus ();

    pole_predictor dut (
        .clk         (clk),
        .reset       (reset),
        .test_mode   (test_mode),
        .scan_enable (scan_enable),
        .scan_in0    (scan_in0),
        .scan_in1    (scan_in1),
        .scan_in2    (scan_in2),
        .scan_in3    (scan_in3),
        .scan_in4    (scan_in4),
        .scan_out0   (scan_out0),
        .scan_out1   (scan_out1),
        .scan_out2   (scan_out2),
        .scan_out3   (scan_out3),
        .scan_out4   (scan_out4),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] limc_ref(input logic [15:0] t);
        int v;
        logic [15:0] r;
        v = int'($signed(t));
        if (v > 12288)  v = 12288;
        if (v < -12288) v = -12288;
        r = v[15:0];
        return r;
    endfunction

    function automatic logic [15:0] fmult_ref(input logic [15:0] an, input logic [10:0] sr);
        int a, mag, e, mant, srs, sre, srm, wexp, wmant, wmag, res;
        logic [15:0] o;
        a    = int'($signed(an));
        mag  = ((a < 0) ? -a : a) / 4;
        mag  = mag % 8192;
        e    = 0;
        while ((mag >> e) != 0) e++;
        mant = (mag == 0) ? 32 : ((mag * 64) >> e);
        srs  = int'(sr[10]);
        sre  = int'(sr[9:6]);
        srm  = int'(sr[5:0]);
        wexp  = sre + e;
        wmant = (srm * mant + 48) / 16;
        if (wexp <= 26) wmag = (wmant * 128) >> (26 - wexp);
        else            wmag = ((wmant * 128) << (wexp - 26)) % 32768;
        res = ((srs != 0) != (a < 0)) ? -wmag : wmag;
        o = res[15:0];
        return o;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_upd(input logic [15:0] t);
        bus.upd = 1'b1;
        bus.A2T = t;
        tick();
        bus.upd  = 1'b0;
        a2_model = limc_ref(t);
        check("a2_after_upd", bus.A2, a2_model);
    endtask

    task automatic run_eval(input string tag, input logic [15:0] a1, input logic [10:0] sr1,
                            input logic [10:0] sr2, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] es);
        bus.A1    = a1;
        bus.SR1   = sr1;
        bus.SR2   = sr2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check({tag, "_busy"}, {15'b0, bus.busy}, 16'd1);
        tick();
        tick();
        check({tag, "_done_early"}, {15'b0, bus.done}, 16'd0);
        tick();
        check({tag, "_done"}, {15'b0, bus.done}, 16'd1);
        check({tag, "_wa1"}, bus.WA1, e1);
        check({tag, "_wa2"}, bus.WA2, e2);
        check({tag, "_sep"}, bus.SEP, es);
        tick();
        check({tag, "_done_drop"}, {15'b0, bus.done}, 16'd0);
        check({tag, "_idle"}, {15'b0, bus.busy}, 16'd0);
    endtask

    initial begin
        logic [15:0] a1r, w1, w2;
        logic [10:0] s1, s2;

        reset = 1'b0;
        test_mode = 1'b0; scan_enable = 1'b0;
        scan_in0 = 1'b0; scan_in1 = 1'b0; scan_in2 = 1'b0; scan_in3 = 1'b0; scan_in4 = 1'b0;
        bus.upd = 1'b0; bus.A2T = 16'd0; bus.A1 = 16'd0;
        bus.SR1 = 11'd0; bus.SR2 = 11'd0; bus.start = 1'b0;
        a2_model = 16'd0;
        tick();
        tick();
        check("rst_a2", bus.A2, 16'd0);
        check("rst_sep", bus.SEP, 16'd0);
        check("rst_flags", {14'b0, bus.busy, bus.done}, 16'd0);
        check("rst_scan", {11'b0, scan_out0, scan_out1, scan_out2, scan_out3, scan_out4}, 16'd0);
        reset = 1'b1;
        tick();

        run_eval("zero", 16'h0000, 11'h020, 11'h020, 16'h0000, 16'h0000, 16'h0000);

        do_upd(16'h4000);
        check("limc_hi", bus.A2, 16'h3000);
        run_eval("pos", 16'h4000, 11'h1E0, 11'h1E0, 16'd134, 16'd99, 16'd233);

        do_upd(16'hC000);
        check("limc_lo", bus.A2, 16'hD000);
        run_eval("neg", 16'h4000, 11'h1E0, 11'h1E0, 16'd134, 16'hFF9D, 16'd35);

        // Back-to-back: restarts while busy are dropped; a restart in the done cycle is taken.
        bus.start = 1'b1; bus.upd = 1'b1; bus.A2T = 16'h0000;
        tick();
        bus.upd = 1'b0; a2_model = 16'd0;
        check("b2b_busy", {15'b0, bus.busy}, 16'd1);
        tick();
        tick();
        bus.start = 1'b0;
        check("b2b_a2_updated", bus.A2, 16'h0000);
        tick();
        check("b2b_done1", {15'b0, bus.done}, 16'd1);
        check("b2b_wa2_old", bus.WA2, 16'hFF9D);
        check("b2b_sep1", bus.SEP, 16'd35);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("b2b_second_busy", {15'b0, bus.busy}, 16'd1);
        tick();
        tick();
        check("b2b_no_early", {15'b0, bus.done}, 16'd0);
        tick();
        check("b2b_done2", {15'b0, bus.done}, 16'd1);
        check("b2b_wa2_new", bus.WA2, 16'h0000);
        check("b2b_sep2", bus.SEP, 16'd134);
        tick();

        do_upd(16'h1000);
        check("limc_pass", bus.A2, 16'h1000);

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        #2 reset = 1'b0;
        #1;
        check("abort_outs", bus.WA1 | bus.WA2 | bus.SEP | bus.A2, 16'd0);
        check("abort_flags", {14'b0, bus.busy, bus.done}, 16'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_done", {15'b0, bus.done}, 16'd0);
        end
        reset = 1'b1;
        a2_model = 16'd0;
        tick();
        run_eval("post_rst", 16'h4000, 11'h1E0, 11'h1E0, 16'd134, 16'd0, 16'd134);

        for (int k = 0; k < 16; k++) begin
            do_upd(16'($urandom));
            a1r = 16'($urandom_range(0, 30720)) - 16'd15360;
            s1  = 11'($urandom);
            s2  = 11'($urandom);
            w1  = fmult_ref(a1r, s1);
            w2  = fmult_ref(a2_model, s2);
            run_eval("rand", a1r, s1, s2, w1, w2, w1 + w2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
